// File: rtl/mode_stopwatch_lap.sv
// MM:SS:CC stopwatch with a LAP_DEPTH-entry lap ring and a 32-character LCD text view.
// Optional macro LAP_DELTA_EN: laps store time since the previous lap instead of absolute split.
module mode_stopwatch_lap #(
  parameter int unsigned CLK_HZ    = 50000000,
  parameter int unsigned TICK_HZ   = 100,
  parameter int unsigned LAP_DEPTH = 4,
  parameter int unsigned MAX_MIN   = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw_in,
  input  logic [4:0] index,
  output logic [7:0] out,
  output logic       running,
  output logic [3:0] lap_count
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned PW  = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_e;

  typedef struct packed {
    logic [6:0] mm;
    logic [5:0] ss;
    logic [6:0] cc;
  } tm_t;

  // One centisecond step with cascading carries and wrap after MAX_MIN:59:99.
  function automatic tm_t incr(input tm_t t);
    tm_t r;
    r = t;
    if (t.cc == 7'd99) begin
      r.cc = '0;
      if (t.ss == 6'd59) begin
        r.ss = '0;
        r.mm = (t.mm == 7'(MAX_MIN)) ? '0 : t.mm + 7'd1;
      end else begin
        r.ss = t.ss + 6'd1;
      end
    end else begin
      r.cc = t.cc + 7'd1;
    end
    return r;
  endfunction

  // Character at position pos of "MM:SS:CC".
  function automatic logic [7:0] fmt(input tm_t t, input logic [2:0] pos);
    logic [6:0] v;
    case (pos)
      3'd0, 3'd1: v = t.mm;
      3'd3, 3'd4: v = 7'(t.ss);
      default:    v = t.cc;
    endcase
    if (pos == 3'd2 || pos == 3'd5) return 8'h3A;
    if (pos == 3'd0 || pos == 3'd3 || pos == 3'd6) return 8'h30 + 8'(v / 7'd10);
    return 8'h30 + 8'(v % 7'd10);
  endfunction

  state_e        state_q, state_d;
  logic [3:0]    sw_prev_q, sw_prev_d;
  logic [DW-1:0] div_q, div_d;
  tm_t           time_q, time_d;
  tm_t           lap_q [LAP_DEPTH];
  tm_t           lap_d [LAP_DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] view_q, view_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [7:0]    out_q, out_d;
  logic          running_q, running_d;
`ifdef LAP_DELTA_EN
  tm_t           seg_q, seg_d;
`endif

  logic [3:0]    ev_c;
  logic          tick_c;
  tm_t           cap_c;
  logic [4:0]    slot_sum_c;
  logic [PW-1:0] slot_c;
  logic [7:0]    char_c;

  assign ev_c   = sw_in & ~sw_prev_q;
  assign tick_c = (state_q == S_RUN) && (div_q == DW'(DIV - 1));

`ifdef LAP_DELTA_EN
  assign cap_c = seg_q;
`else
  assign cap_c = time_q;
`endif

  // Newest lap is one behind the write pointer; view walks backwards from it.
  assign slot_sum_c = 5'(LAP_DEPTH) + 5'(wr_q) - 5'd1 - 5'(view_q);
  assign slot_c     = PW'(slot_sum_c % 5'(LAP_DEPTH));

  // Next-state logic: controls, counters and lap ring.
  always_comb begin
    state_d   = state_q;
    sw_prev_d = sw_in;
    time_d    = time_q;
    lap_d     = lap_q;
    wr_d      = wr_q;
    view_d    = view_q;
    cnt_d     = cnt_q;
`ifdef LAP_DELTA_EN
    seg_d     = seg_q;
`endif

    if (tick_c) begin
      time_d = incr(time_q);
`ifdef LAP_DELTA_EN
      seg_d  = incr(seg_q);
`endif
    end

    case (state_q)
      S_IDLE:  if (ev_c[0]) state_d = S_RUN;
      S_RUN:   if (ev_c[0]) state_d = S_PAUSE;
      S_PAUSE: if (ev_c[0]) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase

    div_d = (state_q == S_RUN && state_d == S_RUN && !tick_c) ? div_q + 1'b1 : '0;

    if (ev_c[2] && cnt_q != 4'd0) begin
      view_d = (4'(view_q) + 4'd1 == cnt_q) ? '0 : view_q + 1'b1;
    end

    // Lap is gated on the state at the start of the cycle.
    if (ev_c[1] && state_q == S_RUN) begin
      lap_d[wr_q] = cap_c;
      wr_d        = (wr_q == PW'(LAP_DEPTH - 1)) ? '0 : wr_q + 1'b1;
      if (cnt_q != 4'(LAP_DEPTH)) cnt_d = cnt_q + 4'd1;
      view_d      = '0;
`ifdef LAP_DELTA_EN
      seg_d       = '0;
`endif
    end

    if (ev_c[3]) begin
      state_d = S_IDLE;
      time_d  = '0;
      for (int i = 0; i < LAP_DEPTH; i++) lap_d[i] = '0;
      wr_d    = '0;
      view_d  = '0;
      cnt_d   = '0;
      div_d   = '0;
`ifdef LAP_DELTA_EN
      seg_d   = '0;
`endif
    end

    running_d = (state_d == S_RUN);
    out_d     = char_c;
  end

  // LCD character for the requested position.
  always_comb begin
    char_c = 8'h20;
    if (index < 5'd8) begin
      char_c = fmt(time_q, index[2:0]);
    end else if (index >= 5'd19 && index <= 5'd26) begin
      if (cnt_q == 4'd0) begin
        char_c = (index == 5'd21 || index == 5'd24) ? 8'h3A : 8'h2D;
      end else begin
        char_c = fmt(lap_q[slot_c], 3'(index - 5'd19));
      end
    end else begin
      case (index)
        5'd9: begin
          case (state_q)
            S_RUN:   char_c = 8'h52;
            S_PAUSE: char_c = 8'h50;
            default: char_c = 8'h49;
          endcase
        end
        5'd11: char_c = 8'h4C;
        5'd12: char_c = 8'h30 + 8'(cnt_q);
`ifdef LAP_DELTA_EN
        5'd15: char_c = 8'h44;
`endif
        5'd16: char_c = 8'h4C;
        5'd17: char_c = (cnt_q == 4'd0) ? 8'h2D : 8'h31 + 8'(view_q);
        default: char_c = 8'h20;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sw_prev_q <= 4'b1111;
      div_q     <= '0;
      time_q    <= '0;
      for (int i = 0; i < LAP_DEPTH; i++) lap_q[i] <= '0;
      wr_q      <= '0;
      view_q    <= '0;
      cnt_q     <= '0;
      out_q     <= 8'h00;
      running_q <= 1'b0;
`ifdef LAP_DELTA_EN
      seg_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      sw_prev_q <= sw_prev_d;
      div_q     <= div_d;
      time_q    <= time_d;
      lap_q     <= lap_d;
      wr_q      <= wr_d;
      view_q    <= view_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      running_q <= running_d;
`ifdef LAP_DELTA_EN
      seg_q     <= seg_d;
`endif
    end
  end

  assign out       = out_q;
  assign running   = running_q;
  assign lap_count = cnt_q;

endmodule
